// File: rtl/asmd_counter_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : asmd_counter_ctrl_param
// Purpose  : Parametrised ASMD controller plus datapath.
//            A start in idle clears counter A and flag F. The block then counts
//            A up and samples A[E_BIT] into E on each count cycle. Counting
//            stops when A[E_BIT] and A[STOP_BIT] are both set. F is then set
//            and done pulses for one cycle. Abort cancels a run and returns
//            the block to idle.
// Ports    : clk        in   1      rising-edge clock
//            rst        in   1      asynchronous reset, active-high
//            start      in   1      begin a run (sampled only in S_IDLE)
//            abort      in   1      cancel a run (wins over start)
//            A          out  WIDTH  counter register
//            E          out  1      flag register, loaded from A[E_BIT]
//            F          out  1      finished flag register
//            busy       out  1      state != S_IDLE
//            done       out  1      1 while state == S_FIN
//            state      out  2      current state (debug)
//            next_state out  2      combinational next state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module asmd_counter_ctrl_param #(
  parameter int WIDTH    = 4,
  parameter int E_BIT    = 2,
  parameter int STOP_BIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] A,
  output logic             E,
  output logic             F,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state,
  output logic [1:0]       next_state
);

  // --------------------------------------------------------------------------
  // Parameter sanity: a bad bit index must stop elaboration instead of
  // silently selecting a nonexistent counter bit.
  // --------------------------------------------------------------------------
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("asmd_counter_ctrl_param: WIDTH must be >= 2");
    end
    if ((E_BIT < 0) || (E_BIT >= WIDTH)) begin : g_bad_e_bit
      $error("asmd_counter_ctrl_param: E_BIT out of range");
    end
    if ((STOP_BIT < 0) || (STOP_BIT >= WIDTH)) begin : g_bad_stop_bit
      $error("asmd_counter_ctrl_param: STOP_BIT out of range");
    end
  endgenerate

  // 2'b10 is deliberately left unused; the state logic steers it back to idle.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CNT  = 2'b01,
    S_FIN  = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] C_A_ZERO = '0;
  localparam logic [WIDTH-1:0] C_A_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             e_q, e_d;
  logic             f_q, f_d;

  // The stop test uses the current (pre-increment) value of A. Because
  // all-ones A always satisfies it, A can never wrap inside a run.
  logic             stop_hit;
  assign stop_hit = a_q[E_BIT] & a_q[STOP_BIT];

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= C_A_ZERO;
      e_q     <= 1'b0;
      f_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      e_q     <= e_d;
      f_q     <= f_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and register-transfer logic. Every register holds by default.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    e_d     = e_q;
    f_d     = f_q;

    case (state_q)
      S_IDLE: begin
        // Abort has priority, so a simultaneous start is dropped.
        if (!abort && start) begin
          a_d     = C_A_ZERO;
          f_d     = 1'b0;
          state_d = S_CNT;
        end
      end

      S_CNT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          a_d     = a_q + C_A_ONE;
          e_d     = a_q[E_BIT];
          state_d = stop_hit ? S_FIN : S_CNT;
        end
      end

      S_FIN: begin
        f_d     = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign A          = a_q;
  assign E          = e_q;
  assign F          = f_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign state      = state_q;
  assign next_state = state_d;

endmodule
`default_nettype wire

// File: tb/tb_asmd_counter_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_asmd_counter_ctrl_param
// Purpose  : Self-checking bench for asmd_counter_ctrl_param. It uses a
//            directed vector table on the default instance, plus hand-written
//            sequences for back-to-back start, asynchronous reset and a
//            WIDTH=6 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asmd_counter_ctrl_param;

  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_CNT  = 2'b01;
  localparam logic [1:0] C_FIN  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] a0;
  logic       e0, f0, busy0, done0;
  logic [1:0] st0, nst0;

  // WIDTH=6, E_BIT=1, STOP_BIT=4 instance
  logic       rst1 = 1'b1, start1 = 1'b0, abort1 = 1'b0;
  logic [5:0] a1;
  logic       e1, f1, busy1, done1;
  logic [1:0] st1, nst1;

  asmd_counter_ctrl_param u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .A(a0), .E(e0), .F(f0), .busy(busy0), .done(done0),
    .state(st0), .next_state(nst0)
  );

  asmd_counter_ctrl_param #(.WIDTH(6), .E_BIT(1), .STOP_BIT(4)) u_dut6 (
    .clk(clk), .rst(rst1), .start(start1), .abort(abort1),
    .A(a1), .E(e1), .F(f1), .busy(busy1), .done(done1),
    .state(st1), .next_state(nst1)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst, start, abort;
    logic [3:0] a;
    logic       e, f, busy, done;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic ab,
                     input logic [3:0] a, input logic e, input logic f,
                     input logic b, input logic d, input logic [1:0] st);
    vec_t v;
    v.rst = r; v.start = s; v.abort = ab;
    v.a = a; v.e = e; v.f = f; v.busy = b; v.done = d; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // advance one clock, then sample 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    // ---------------- table: reset, full default run, abort cases ----------
    add(1,0,0,  0,0,0, 0,0, C_IDLE);   // reset state
    add(0,1,0,  0,0,0, 1,0, C_CNT);    // launch: A=0
    add(0,0,0,  1,0,0, 1,0, C_CNT);
    add(0,0,0,  2,0,0, 1,0, C_CNT);
    add(0,0,0,  3,0,0, 1,0, C_CNT);
    add(0,0,0,  4,0,0, 1,0, C_CNT);    // E sampled A=3
    add(0,0,0,  5,1,0, 1,0, C_CNT);    // E sampled A=4
    add(0,0,0,  6,1,0, 1,0, C_CNT);
    add(0,0,0,  7,1,0, 1,0, C_CNT);
    add(0,0,0,  8,1,0, 1,0, C_CNT);
    add(0,0,0,  9,0,0, 1,0, C_CNT);    // E sampled A=8
    add(0,0,0, 10,0,0, 1,0, C_CNT);
    add(0,0,0, 11,0,0, 1,0, C_CNT);
    add(0,0,0, 12,0,0, 1,0, C_CNT);
    add(0,0,0, 13,1,0, 1,1, C_FIN);    // stop seen at A=12
    add(0,0,0, 13,1,1, 0,0, C_IDLE);   // F set
    add(0,0,0, 13,1,1, 0,0, C_IDLE);   // hold in idle
    add(0,1,1, 13,1,1, 0,0, C_IDLE);   // abort+start: no change
    add(0,1,0,  0,1,0, 1,0, C_CNT);    // relaunch: A,F cleared, E kept
    add(0,0,0,  1,0,0, 1,0, C_CNT);
    add(0,0,0,  2,0,0, 1,0, C_CNT);
    add(0,0,0,  3,0,0, 1,0, C_CNT);
    add(0,0,0,  4,0,0, 1,0, C_CNT);
    add(0,0,0,  5,1,0, 1,0, C_CNT);
    add(0,0,0,  6,1,0, 1,0, C_CNT);
    add(0,0,0,  7,1,0, 1,0, C_CNT);
    add(0,0,0,  8,1,0, 1,0, C_CNT);
    add(0,0,1,  8,1,0, 0,0, C_IDLE);   // abort: A/E/F hold, no done
    add(0,0,0,  8,1,0, 0,0, C_IDLE);

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      start = vecs[i].start;
      abort = vecs[i].abort;
      step();
      chk($sformatf("vec%0d A", i),     32'(a0),    32'(vecs[i].a));
      chk($sformatf("vec%0d E", i),     32'(e0),    32'(vecs[i].e));
      chk($sformatf("vec%0d F", i),     32'(f0),    32'(vecs[i].f));
      chk($sformatf("vec%0d busy", i),  32'(busy0), 32'(vecs[i].busy));
      chk($sformatf("vec%0d done", i),  32'(done0), 32'(vecs[i].done));
      chk($sformatf("vec%0d state", i), 32'(st0),   32'(vecs[i].st));
    end

    // ---------------- back-to-back: start held across S_FIN -----------------
    start = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (st0 != C_FIN && n < 40);
    chk("b2b edges to FIN", 32'(n), 32'd14);
    chk("b2b FIN A", 32'(a0), 32'd13);
    step();
    chk("b2b idle state", 32'(st0), 32'(C_IDLE));
    chk("b2b idle A", 32'(a0), 32'd13);
    chk("b2b idle F", 32'(f0), 32'd1);
    chk("b2b idle done", 32'(done0), 32'd0);
    step();
    chk("b2b relaunch state", 32'(st0), 32'(C_CNT));
    chk("b2b relaunch A", 32'(a0), 32'd0);
    chk("b2b relaunch F", 32'(f0), 32'd0);
    start = 1'b0;
    abort = 1'b1;
    step();
    chk("b2b abort state", 32'(st0), 32'(C_IDLE));
    abort = 1'b0;

    // ---------------- asynchronous reset mid-count ---------------------------
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("async pre A", 32'(a0), 32'd6);
    chk("async pre E", 32'(e0), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async A", 32'(a0), 32'd0);
    chk("async E", 32'(e0), 32'd0);
    chk("async F", 32'(f0), 32'd0);
    chk("async state", 32'(st0), 32'(C_IDLE));
    chk("async busy", 32'(busy0), 32'd0);
    step();
    chk("async hold A", 32'(a0), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("post-rst idle state", 32'(st0), 32'(C_IDLE));
    chk("post-rst idle A", 32'(a0), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post-rst start state", 32'(st0), 32'(C_CNT));

    // ---------------- WIDTH=6, E_BIT=1, STOP_BIT=4 ---------------------------
    step();
    chk("w6 reset A", 32'(a1), 32'd0);
    chk("w6 reset state", 32'(st1), 32'(C_IDLE));
    rst1   = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("w6 launch state", 32'(st1), 32'(C_CNT));
    n = 0;
    while (st1 == C_CNT && n < 100) begin
      step();
      n++;
    end
    chk("w6 count cycles", 32'(n), 32'd19);
    chk("w6 FIN state", 32'(st1), 32'(C_FIN));
    chk("w6 final A", 32'(a1), 32'd19);
    chk("w6 final E", 32'(e1), 32'd1);
    chk("w6 done", 32'(done1), 32'd1);
    step();
    chk("w6 F", 32'(f1), 32'd1);
    chk("w6 idle state", 32'(st1), 32'(C_IDLE));
    chk("w6 idle A", 32'(a1), 32'd19);
    chk("w6 idle busy", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
